vram_scanout: RTL and testbench

Video scanout stage sitting directly downstream of the dual-clock framebuffer RAM: generates raster timing, drives the RAM's read port (port B, clocked by the same `clk`) with linear pixel addresses, and converts the returned RGB332 bytes into 24-bit RGB with aligned sync/blank. Pixel rate is set by a clock enable. The CPU/loader side writes the other RAM port independently. Double buffering is supported through a page bit latched once per frame.

---
 rtl/vram_scanout.sv | 172 +++++++++++++++++
 tb/tb_vram_scanout.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_scanout.sv
// vram_scanout
//   Raster scanout stage downstream of the framebuffer RAM. Generates the
//   line/frame counters, addresses RAM port B with a linear pixel index
//   (page bit in the MSB), and expands the returned RGB332 bytes to RGB888
//   with sync/blank flags aligned to the pixel data. All state advances only
//   on ce_pix; the pipeline is three stages deep (counters, address, colour).
//
// Ports
//   clk       in   single clock, also clocks RAM port B
//   reset     in   synchronous, active-high
//   ce_pix    in   pixel enable, never high on two consecutive clk cycles
//   page      in   requested display page, latched at frame wrap
//   ram_addr  out  RAM port B address {page, linear index}, registered
//   ram_q     in   RAM port B read data, valid one clk after ram_addr
//   r, g, b   out  RGB888 pixel colour (zero outside the visible area)
//   hs, vs    out  active-high syncs
//   de        out  data enable (visible pixel)
//   vblank    out  high while the output line is >= V_ACTIVE
module vram_scanout #(
  parameter int H_ACTIVE = 320,
  parameter int H_FP     = 8,
  parameter int H_SYNC   = 32,
  parameter int H_BP     = 40,
  parameter int V_ACTIVE = 240,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 15,
  parameter int ADDR_W   = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce_pix,
  input  logic              page,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_q,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic              hs,
  output logic              vs,
  output logic              de,
  output logic              vblank
);

  localparam int HT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HC_W  = $clog2(HT);
  localparam int VC_W  = $clog2(VT);
  localparam int LIN_W = ADDR_W - 1;

  localparam logic [HC_W-1:0] HC_LAST = HC_W'(HT - 1);
  localparam logic [HC_W-1:0] HA_END  = HC_W'(H_ACTIVE);
  localparam logic [HC_W-1:0] HS_BEG  = HC_W'(H_ACTIVE + H_FP);
  localparam logic [HC_W-1:0] HS_END  = HC_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VC_W-1:0] VC_LAST = VC_W'(VT - 1);
  localparam logic [VC_W-1:0] VA_END  = VC_W'(V_ACTIVE);
  localparam logic [VC_W-1:0] VS_BEG  = VC_W'(V_ACTIVE + V_FP);
  localparam logic [VC_W-1:0] VS_END  = VC_W'(V_ACTIVE + V_FP + V_SYNC);

  // 3-bit channel to 8 bits by bit replication (0 -> 0x00, 7 -> 0xFF)
  function automatic logic [7:0] expand3(input logic [2:0] c);
    return {c, c, c[2:1]};
  endfunction

  // 2-bit channel to 8 bits by bit replication (0 -> 0x00, 3 -> 0xFF)
  function automatic logic [7:0] expand2(input logic [1:0] c);
    return {c, c, c, c};
  endfunction

  logic [HC_W-1:0]  hc_p0;
  logic [VC_W-1:0]  vc_p0;
  logic [LIN_W-1:0] lin_p0;
  logic             page_l;
  logic             vld_p0, hs_p0, vs_p0, vb_p0, h_last_p0, f_last_p0;

  logic             vld_p1, hs_p1, vs_p1, vb_p1;
  logic [ADDR_W-1:0] addr_p1;

  logic             vld_p2, hs_p2, vs_p2, vb_p2;
  logic [7:0]       r_p2, g_p2, b_p2;

  // ---- stage 0: raster counters and position decode ----
  always_comb begin
    vld_p0    = (hc_p0 < HA_END) && (vc_p0 < VA_END);
    hs_p0     = (hc_p0 >= HS_BEG) && (hc_p0 < HS_END);
    vs_p0     = (vc_p0 >= VS_BEG) && (vc_p0 < VS_END);
    vb_p0     = (vc_p0 >= VA_END);
    h_last_p0 = (hc_p0 == HC_LAST);
    f_last_p0 = h_last_p0 && (vc_p0 == VC_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hc_p0  <= '0;
      vc_p0  <= '0;
      lin_p0 <= '0;
      page_l <= 1'b0;
    end else if (ce_pix) begin
      if (h_last_p0) begin
        hc_p0 <= '0;
        vc_p0 <= (vc_p0 == VC_LAST) ? '0 : vc_p0 + VC_W'(1);
      end else begin
        hc_p0 <= hc_p0 + HC_W'(1);
      end
      // Linear index runs across visible pixels only, so no v*H multiply.
      if (f_last_p0) begin
        lin_p0 <= '0;
        page_l <= page;
      end else if (vld_p0) begin
        lin_p0 <= lin_p0 + LIN_W'(1);
      end
    end
  end

  // ---- stage 1: RAM address and registered decode ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      hs_p1   <= 1'b0;
      vs_p1   <= 1'b0;
      vb_p1   <= 1'b0;
      addr_p1 <= '0;
    end else if (ce_pix) begin
      vld_p1 <= vld_p0;
      hs_p1  <= hs_p0;
      vs_p1  <= vs_p0;
      vb_p1  <= vb_p0;
      if (vld_p0) begin
        addr_p1 <= {page_l, lin_p0};
      end
    end
  end

  // ---- stage 2: colour expansion and output flags ----
  // ram_q has had at least one idle clk to settle since addr_p1 changed,
  // because ce_pix is never high on consecutive cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p2 <= 1'b0;
      hs_p2  <= 1'b0;
      vs_p2  <= 1'b0;
      vb_p2  <= 1'b0;
      r_p2   <= '0;
      g_p2   <= '0;
      b_p2   <= '0;
    end else if (ce_pix) begin
      vld_p2 <= vld_p1;
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
      vb_p2  <= vb_p1;
      if (vld_p1) begin
        r_p2 <= expand3(ram_q[7:5]);
        g_p2 <= expand3(ram_q[4:2]);
        b_p2 <= expand2(ram_q[1:0]);
      end else begin
        r_p2 <= '0;
        g_p2 <= '0;
        b_p2 <= '0;
      end
    end
  end

  assign ram_addr = addr_p1;
  assign r        = r_p2;
  assign g        = g_p2;
  assign b        = b_p2;
  assign hs       = hs_p2;
  assign vs       = vs_p2;
  assign de       = vld_p2;
  assign vblank   = vb_p2;

endmodule

// File: tb/tb_vram_scanout.sv
// tb_vram_scanout
//   Drives two scanout instances from shared clk/reset/ce_pix/page: one with
//   the full 320x240 geometry (line-level timing and colour) and one with a
//   reduced raster so whole frames, vsync, vblank and page switching fit in a
//   short run. A reference raster model pushes the expected output tuple per
//   ce_pix into a queue; a monitor pops and compares on every ce_pix.
module tb_vram_scanout;

  localparam int S_HA  = 16;
  localparam int S_HFP = 2;
  localparam int S_HS  = 4;
  localparam int S_HBP = 2;
  localparam int S_VA  = 6;
  localparam int S_VFP = 1;
  localparam int S_VS  = 2;
  localparam int S_VBP = 1;
  localparam int LOG_N = 512;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic        vb;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic [17:0] addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, ce_pix, page;
  logic [17:0] addr0, addr1;
  logic [7:0]  q0, q1;
  logic [7:0]  r0, g0, b0, r1, g1, b1;
  logic        hs0, vs0, de0, vb0, hs1, vs1, de1, vb1;

  always #5 clk = ~clk;

  vram_scanout u_big (
    .clk(clk), .reset(reset), .ce_pix(ce_pix), .page(page),
    .ram_addr(addr0), .ram_q(q0),
    .r(r0), .g(g0), .b(b0), .hs(hs0), .vs(vs0), .de(de0), .vblank(vb0)
  );

  vram_scanout #(
    .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP), .ADDR_W(18)
  ) u_small (
    .clk(clk), .reset(reset), .ce_pix(ce_pix), .page(page),
    .ram_addr(addr1), .ram_q(q1),
    .r(r1), .g(g1), .b(b1), .hs(hs1), .vs(vs1), .de(de1), .vblank(vb1)
  );

  // RAM port B models: one clk read latency.
  function automatic logic [7:0] ram_f(input int d, input logic [17:0] a);
    if (d == 0) return a[7:0];
    return a[7:0] ^ (a[17] ? 8'h5A : 8'h00);
  endfunction

  always @(posedge clk) begin
    q0 <= ram_f(0, addr0);
    q1 <= ram_f(1, addr1);
  end

  int   chk_cnt = 0;
  int   err_cnt = 0;
  int   ce_idx  = 0;
  exp_t sb0[$];
  exp_t sb1[$];

  logic        de_log [LOG_N];
  logic        hs_log [LOG_N];
  logic [23:0] rgb_log[LOG_N];
  logic        vs1_log[LOG_N];
  logic        vb1_log[LOG_N];
  logic [17:0] a1_log [LOG_N];

  int          mh[2], mv[2];
  logic        mpl[2];
  logic [17:0] maddr[2];
  exp_t        mout[2], ms1[2];

  // RGB332 to RGB888 as scaled arithmetic: 3-bit -> round(c*255/7), 2-bit -> c*85
  function automatic logic [23:0] rgb_of(input logic [7:0] q);
    int rr, gg, bb;
    rr = (int'(q[7:5]) * 255 + 3) / 7;
    gg = (int'(q[4:2]) * 255 + 3) / 7;
    bb = int'(q[1:0]) * 85;
    return {rr[7:0], gg[7:0], bb[7:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mh[d] = 0; mv[d] = 0; mpl[d] = 1'b0; maddr[d] = '0;
      mout[d] = '0; ms1[d] = '0;
    end
  endtask

  // Push what the outputs show during this ce cycle, then advance the model
  // by one pixel clock.
  task automatic model_step();
    exp_t e, nx;
    int ha, hfp, hsw, ht, va, vfp, vsw, vt, lin;
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        ha = 320; hfp = 8; hsw = 32; ht = 400; va = 240; vfp = 3; vsw = 4; vt = 262;
      end else begin
        ha = S_HA; hfp = S_HFP; hsw = S_HS; ht = S_HA + S_HFP + S_HS + S_HBP;
        va = S_VA; vfp = S_VFP; vsw = S_VS; vt = S_VA + S_VFP + S_VS + S_VBP;
      end
      e = mout[d];
      e.addr = maddr[d];
      if (d == 0) sb0.push_back(e); else sb1.push_back(e);
      nx = ms1[d];
      if (nx.de) {nx.r, nx.g, nx.b} = rgb_of(ram_f(d, maddr[d]));
      mout[d] = nx;
      ms1[d] = '0;
      ms1[d].de = (mh[d] < ha) && (mv[d] < va);
      ms1[d].hs = (mh[d] >= ha + hfp) && (mh[d] < ha + hfp + hsw);
      ms1[d].vs = (mv[d] >= va + vfp) && (mv[d] < va + vfp + vsw);
      ms1[d].vb = (mv[d] >= va);
      if (ms1[d].de) begin
        lin = mv[d] * ha + mh[d];
        maddr[d] = {mpl[d], lin[16:0]};
      end
      if (mh[d] == ht - 1) begin
        mh[d] = 0;
        if (mv[d] == vt - 1) begin
          mv[d] = 0;
          mpl[d] = page;
        end else begin
          mv[d]++;
        end
      end else begin
        mh[d]++;
      end
    end
  endtask

  task automatic sb_cmp(input int d, input exp_t a);
    exp_t e;
    chk_cnt++;
    if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
      err_cnt++;
      $display("FAIL sb%0d_empty ce=%0d: output with no expected entry", d, ce_idx);
      return;
    end
    e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
    if (a !== e) begin
      err_cnt++;
      $display("FAIL sb%0d ce=%0d: got de/hs/vs/vb=%b%b%b%b rgb=%02h%02h%02h addr=%05h, expected de/hs/vs/vb=%b%b%b%b rgb=%02h%02h%02h addr=%05h",
               d, ce_idx, a.de, a.hs, a.vs, a.vb, a.r, a.g, a.b, a.addr,
               e.de, e.hs, e.vs, e.vb, e.r, e.g, e.b, e.addr);
    end
  endtask

  task automatic monitor_loop();
    exp_t a;
    forever begin
      @(negedge clk);
      if (reset) begin
        ce_idx = 0;
      end else if (ce_pix) begin
        ce_idx++;
        a = {de0, hs0, vs0, vb0, r0, g0, b0, addr0};
        sb_cmp(0, a);
        a = {de1, hs1, vs1, vb1, r1, g1, b1, addr1};
        sb_cmp(1, a);
        if (ce_idx < LOG_N) begin
          de_log[ce_idx]  = de0;
          hs_log[ce_idx]  = hs0;
          rgb_log[ce_idx] = {r0, g0, b0};
          vs1_log[ce_idx] = vs1;
          vb1_log[ce_idx] = vb1;
          a1_log[ce_idx]  = addr1;
        end
      end
    end
  endtask

  task automatic do_ce(input int gap);
    ce_pix = 1'b1;
    model_step();
    @(posedge clk); #1;
    ce_pix = 1'b0;
    repeat (gap - 1) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_big"},    {de0, hs0, vs0, vb0, r0, g0, b0}, 32'h0);
    chk({tag, "_addr_big"},   {14'h0, addr0}, 32'h0);
    chk({tag, "_out_small"},  {de1, hs1, vs1, vb1, r1, g1, b1}, 32'h0);
    chk({tag, "_addr_small"}, {14'h0, addr1}, 32'h0);
  endtask

  initial begin
    int n;
    reset  = 1'b1;
    ce_pix = 1'b0;
    page   = 1'b0;
    model_reset();
    fork
      monitor_loop();
    join_none

    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      ce_pix = (i % 2 == 0);
    end
    @(negedge clk);
    chk_reset_outputs("rst");
    @(posedge clk); #1;
    reset  = 1'b0;
    ce_pix = 1'b0;

    for (int k = 1; k <= 500; k++) begin
      if (k == 100) page = 1'b1;
      do_ce(2);
    end

    chk("de_fill",      {31'h0, de_log[2]},   32'h0);
    chk("de_rise",      {31'h0, de_log[3]},   32'h1);
    chk("de_last",      {31'h0, de_log[322]}, 32'h1);
    chk("de_fall",      {31'h0, de_log[323]}, 32'h0);
    n = 0;
    for (int i = 1; i <= 400; i++) if (de_log[i] === 1'b1) n++;
    chk("de_len",       n, 32'd320);
    chk("hs_pre",       {31'h0, hs_log[330]}, 32'h0);
    chk("hs_rise",      {31'h0, hs_log[331]}, 32'h1);
    chk("hs_last",      {31'h0, hs_log[362]}, 32'h1);
    chk("hs_fall",      {31'h0, hs_log[363]}, 32'h0);
    chk("line1_pre",    {31'h0, de_log[402]}, 32'h0);
    chk("line1_rise",   {31'h0, de_log[403]}, 32'h1);
    chk("px5_rgb",      {8'h0, rgb_log[8]},   32'h002455);
    chk("px255_rgb",    {8'h0, rgb_log[258]}, 32'hFFFFFF);
    chk("vb_pre",       {31'h0, vb1_log[146]}, 32'h0);
    chk("vb_rise",      {31'h0, vb1_log[147]}, 32'h1);
    chk("vb_last",      {31'h0, vb1_log[242]}, 32'h1);
    chk("vb_fall",      {31'h0, vb1_log[243]}, 32'h0);
    chk("vs_pre",       {31'h0, vs1_log[170]}, 32'h0);
    chk("vs_rise",      {31'h0, vs1_log[171]}, 32'h1);
    chk("vs_last",      {31'h0, vs1_log[218]}, 32'h1);
    chk("vs_fall",      {31'h0, vs1_log[219]}, 32'h0);
    chk("vs2_pre",      {31'h0, vs1_log[410]}, 32'h0);
    chk("vs2_rise",     {31'h0, vs1_log[411]}, 32'h1);
    chk("first_addr1",  {14'h0, a1_log[3]},   32'h00001);
    chk("addr_midpage", {14'h0, a1_log[130]}, 32'h00058);
    chk("addr_lastvis", {14'h0, a1_log[241]}, 32'h0005F);
    chk("addr_newpage", {14'h0, a1_log[242]}, 32'h20000);

    for (int k = 0; k < 300; k++) begin
      do_ce(int'($urandom_range(7, 2)));
    end

    for (int k = 0; k < 300; k++) begin
      if (mh[1] == 5 && mv[1] == 3) break;
      do_ce(2);
    end
    chk("pre_mid_rst_de", {31'h0, de0}, 32'h1);
    reset  = 1'b1;
    ce_pix = 1'b1;
    @(posedge clk); #1;
    ce_pix = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midrst");
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();

    for (int k = 0; k < 60; k++) begin
      do_ce(2);
    end
    chk("restart_addr0", {14'h0, a1_log[2]}, 32'h00000);
    chk("restart_addr1", {14'h0, a1_log[3]}, 32'h00001);

    repeat (2) @(negedge clk);
    chk("sb0_drained", sb0.size(), 32'd0);
    chk("sb1_drained", sb1.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
